// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants and the buffered-instruction record.
// Macros are guarded so any later file can rely on them without redefinition.
`ifndef FETCH_CONSTANTS_VH
`define FETCH_CONSTANTS_VH
`define WORD 64
`define INSTR_LEN 32
`define PC_INCR 4
`define FETCH_BUF_DEPTH 2
`endif

package fetch_unit_pkg;
  typedef struct packed {
    logic [`INSTR_LEN-1:0] instr;
    logic [`WORD-1:0]      pc;
  } fetch_entry_t;

  localparam logic [`WORD-1:0] PC_INCR = `WORD'(`PC_INCR);
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
interface fetch_unit_if;
  logic                  imem_req;
  logic [`WORD-1:0]      imem_addr;
  logic [`INSTR_LEN-1:0] imem_rdata;
  logic                  redirect;
  logic [`WORD-1:0]      redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [`INSTR_LEN-1:0] instruction;
  logic [`WORD-1:0]      instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit_buffer.sv
// Two-entry in-order queue of fetched {instr, pc}; flush empties it without
// touching the stored words.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t [1:0] mem_q, mem_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

`ifndef SYNTHESIS
  // Slot reservation at request time makes these unreachable.
  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && count_q == 2'd2)) else $error("fetch_buffer overflow");
      assert (!(pop && count_q == 2'd0)) else $error("fetch_buffer underflow");
    end
  end
`endif
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads, tracks the
// in-flight request and hands buffered words to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [`WORD-1:0] RESET_PC  = '0,
  parameter int unsigned      BUF_DEPTH = `FETCH_BUF_DEPTH
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master fif
);
  logic [`WORD-1:0] pc_q, pc_d;
  logic [`WORD-1:0] req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;

  logic             valid, pop, push, req;
  logic [2:0]       occupancy;
  logic [1:0]       buf_count;
  fetch_entry_t     head, push_data;

  always_comb begin
    valid     = (buf_count != 2'd0) & ~fif.redirect & ~reset;
    pop       = valid & fif.instr_ready;
    // Count the in-flight word as already occupying a slot.
    occupancy = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
    req       = ~reset & ~fif.redirect & (32'(occupancy) < BUF_DEPTH);
    push      = inflight_q & ~kill_q;
    push_data = '{instr: fif.imem_rdata, pc: req_pc_q};
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = req;
    kill_d     = fif.redirect & inflight_q;
    if (req) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + PC_INCR;
    end
    if (fif.redirect) pc_d = {fif.redirect_pc[`WORD-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_buffer u_buf (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .pop       (pop),
    .flush     (fif.redirect),
    .push_data (push_data),
    .head      (head),
    .count     (buf_count)
  );

  assign fif.imem_req    = req;
  assign fif.imem_addr   = pc_q;
  assign fif.instr_valid = valid;
  assign fif.instruction = reset ? '0 : head.instr;
  assign fif.instr_pc    = reset ? '0 : head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model,
// with directed checks for latency, alignment, wrap and stall behaviour.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit #(.RESET_PC(64'h0), .BUF_DEPTH(2)) dut (.clk(clk), .reset(reset), .fif(bus));

  typedef struct { logic [31:0] i; logic [63:0] pc; } ent_t;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  ent_t        mq[$];
  logic [63:0] m_pc = 64'h0;
  logic        m_infl = 1'b0;
  logic [63:0] m_infl_pc = 64'h0;
  logic        m_kill = 1'b0;

  // last observed DUT outputs
  logic        obs_req, obs_valid;
  logic [63:0] obs_addr, obs_pc;
  logic [31:0] obs_instr;

  function automatic logic [31:0] memw(input logic [63:0] a);
    return 32'h8B00_0000 + a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [63:0] rdpc, input logic rdy);
    bit   exp_valid, exp_pop, exp_req;
    ent_t e;
    @(negedge clk);
    reset           = r;
    bus.redirect    = rd;
    bus.redirect_pc = rdpc;
    bus.instr_ready = rdy;
    #1;
    obs_req   = bus.imem_req;
    obs_addr  = bus.imem_addr;
    obs_valid = bus.instr_valid;
    obs_instr = bus.instruction;
    obs_pc    = bus.instr_pc;

    exp_valid = !r && (mq.size() != 0) && !rd;
    exp_pop   = exp_valid && rdy;
    exp_req   = !r && !rd && ((mq.size() + int'(m_infl) - int'(exp_pop)) < 2);
    chk("req", 64'(obs_req), 64'(exp_req));
    if (exp_req) chk("addr", obs_addr, m_pc);
    chk("valid", 64'(obs_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("instr", 64'(obs_instr), 64'(mq[0].i));
      chk("ipc", obs_pc, mq[0].pc);
    end
    if (r) begin
      chk("rst_instr", 64'(obs_instr), 64'h0);
      chk("rst_ipc", obs_pc, 64'h0);
    end

    @(posedge clk);
    if (r) begin
      mq.delete();
      m_pc = 64'h0; m_infl = 1'b0; m_kill = 1'b0;
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (m_infl && !m_kill && !rd) begin
        e.i = memw(m_infl_pc); e.pc = m_infl_pc;
        mq.push_back(e);
      end
      if (rd) mq.delete();
      m_kill = rd && m_infl;
      if (exp_req) m_infl_pc = m_pc;
      m_infl = exp_req;
      if (rd) m_pc = {rdpc[63:2], 2'b00};
      else if (exp_req) m_pc = m_pc + 64'd4;
    end
    #1;
    bus.imem_rdata = obs_req ? memw(obs_addr) : $urandom;
  endtask

  initial begin
    int nreq;
    reset = 1'b1;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0; bus.imem_rdata = '0;

    // streaming from reset
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    step(0, 0, 0, 1); chk("first_addr", obs_addr, 64'h0); chk("first_vld", 64'(obs_valid), 64'h0);
    step(0, 0, 0, 1); chk("second_addr", obs_addr, 64'h4);
    step(0, 0, 0, 1); chk("lat_vld", 64'(obs_valid), 64'h1); chk("lat_pc", obs_pc, 64'h0);
    chk("lat_instr", 64'(obs_instr), 64'h8B00_0000);
    step(0, 0, 0, 1); chk("b2b_pc", obs_pc, 64'h4);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // stall from reset: exactly two requests, PC parks at 8
    step(1, 0, 0, 0);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (obs_req) nreq++;
    end
    chk("stall_nreq", 64'(nreq), 64'd2);
    chk("stall_pc", obs_addr, 64'h8);
    step(0, 0, 0, 1); chk("rel_pc0", obs_pc, 64'h0);
    step(0, 0, 0, 1); chk("rel_pc4", obs_pc, 64'h4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // redirect while streaming with a head handshake in progress
    step(0, 1, 64'h200, 1); chk("redir_vld", 64'(obs_valid), 64'h0); chk("redir_req", 64'(obs_req), 64'h0);
    step(0, 0, 0, 1); chk("redir_addr", obs_addr, 64'h200);
    step(0, 0, 0, 1); chk("redir_gap", 64'(obs_valid), 64'h0);
    step(0, 0, 0, 1); chk("redir_lat", 64'(obs_valid), 64'h1); chk("redir_pc", obs_pc, 64'h200);

    // unaligned target, then back-to-back redirect
    step(0, 1, 64'h103, 1);
    step(0, 0, 0, 1); chk("align", obs_addr, 64'h100);
    step(0, 1, 64'h500, 1); step(0, 1, 64'h604, 1);
    step(0, 0, 0, 1); chk("b2b_redir", obs_addr, 64'h604);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // PC wrap at the top of the address space
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    step(0, 0, 0, 1); chk("wrap_top", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 1); chk("wrap_zero", obs_addr, 64'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // reset with a full queue
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 1); chk("mid_rst_vld", 64'(obs_valid), 64'h0);
    step(0, 0, 0, 1); chk("mid_rst_vld2", 64'(obs_valid), 64'h0); chk("mid_rst_addr", obs_addr, 64'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        rr, rd, rdy;
      logic [63:0] tgt;
      rr  = ($urandom_range(0, 99) < 2);
      rd  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 60);
      tgt = ($urandom_range(0, 19) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                          : {$urandom, $urandom};
      step(rr, rd, tgt, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC, issues requests to a synchronous instruction memory with 1-cycle read latency, and buffers returned words in a 2-entry queue.
- Presents {instruction, pc} to decode over a valid/ready handshake.
- Accepts a branch redirect from the execute stage that flushes all fetched and in-flight instructions.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, output queue entries; only the value 2 is supported.

Ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction-memory read strobe for this cycle.
- imem_addr  output  `WORD  byte address of the request; equals the current PC.
- imem_rdata  input  `INSTR_LEN  instruction word; valid in the cycle after imem_req.
- redirect  input  1  one-cycle pulse; load redirect_pc and flush.
- redirect_pc  input  `WORD  branch target.
- instr_valid  output  1  queue head holds a valid instruction.
- instr_ready  input  1  decode accepts the head this cycle.
- instruction  output  `INSTR_LEN  head instruction word.
- instr_pc  output  `WORD  PC of the head instruction.

Behaviour:
- Reset (synchronous, active-high; takes priority over everything, including mid-operation):
  - pc <= RESET_PC; count <= 0; inflight <= 0; kill <= 0.
  - All queue entries <= 0.
  - Outputs while reset is high: imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
- pop = instr_valid & instr_ready & ~redirect.
- imem_req = ~reset & ~redirect & ((count + inflight - pop) < BUF_DEPTH). Issuing a request reserves a queue slot, so the queue never overflows.
- On imem_req:
  - inflight <= 1; pc <= pc + 4, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
  - The PC of the request is carried alongside the in-flight request.
  - When no request is issued, inflight <= 0.
- Response cycle (inflight=1, kill=0): push {imem_rdata, carried PC} at the queue tail.
- Queue:
  - In-order FIFO; head is driven on instruction/instr_pc.
  - instr_valid = (count != 0) & ~redirect.
  - Push and pop in the same cycle are legal at any count.
  - Overflow and underflow are unreachable by construction. The RTL asserts this in simulation only.
- Redirect cycle:
  - pc <= {redirect_pc[63:2], 2'b00}, i.e. the low bits are forced to 0.
  - count <= 0; imem_req=0; instr_valid=0; any head handshake is ignored.
  - If a request is in flight, kill <= 1, so the response in the next cycle is discarded and not pushed.
  - kill clears after one cycle.
- Redirect in the cycle immediately after a redirect is legal. The newest target wins.
- Timing:
  - First request is issued the cycle after reset deasserts.
  - instr_valid rises 2 cycles after that request.
  - With instr_ready held high: one instruction per cycle.
  - Redirect-to-first-valid-target latency: 3 cycles (redirect, request, response/push, valid).
- Stall: when instr_ready=0 with 2 instructions buffered, imem_req stays 0 and the PC holds. Nothing is lost or duplicated.

Decomposition:
- Shared constants stay in constants.vh: `WORD (64), `INSTR_LEN (32).
- Add to constants.vh: `PC_INCR (4) and `FETCH_BUF_DEPTH (2).
- One sub-module, fetch_buffer:
  - 2-entry FIFO of {`INSTR_LEN instr, `WORD pc} with push, pop, flush and count.
  - Synchronous reset.
- fetch_unit holds the PC, inflight/kill tracking and the request logic.

Test Plan:
- Reset release, RESET_PC=0, memory returns 0x8B000000+addr, instr_ready=1 -> imem_addr 0,4,8,... on consecutive cycles. instr_valid rises 2 cycles after the first req. Then instruction/instr_pc = (0x8B000000,0), (0x8B000004,4), ... back to back.
- Hold instr_ready=0 from the start -> exactly 2 requests (0,4). imem_req then 0 with PC=8. Release ready -> PCs 0,4,8 in order, no duplicates.
- Redirect to 0x200 while count=2 and a request is in flight -> instr_valid=0 in the redirect cycle; stale response dropped. Next delivered instr_pc=0x200, 3 cycles after redirect.
- Redirect with redirect_pc=0x103 -> next imem_addr=0x100.
- Redirect in the same cycle as instr_valid&instr_ready -> pop ignored. The old head is never delivered afterward.
- PC at 0xFFFF_FFFF_FFFF_FFFC -> next imem_addr=0.
- Reset asserted mid-stream with full queue -> next cycle instr_valid=0, imem_req=0, instruction=0, instr_pc=0. Fetch restarts from RESET_PC.
